// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: requester handshake side plus the regfile write-port pins.
interface wb_port_arbiter_if #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    a_i_valid;
   logic [NREQ*AW-1:0] a_i_addr;
   logic [NREQ*DW-1:0] a_i_data;
   logic [NREQ-1:0]    a_o_ready;
   logic               a_i_hold;

   logic               r_wr_en_1;
   logic [AW-1:0]      r_i_addr_rd_1;
   logic [DW-1:0]      r_i_data_rd_1;
   logic               r_wr_en_2;
   logic [AW-1:0]      r_i_addr_rd_2;
   logic [DW-1:0]      r_i_data_rd_2;
   logic [15:0]        a_o_wr_cnt;

   // Requesters plus whoever observes the regfile pins
   modport master (
      output a_i_valid, a_i_addr, a_i_data, a_i_hold,
      input  a_o_ready,
      input  r_wr_en_1, r_i_addr_rd_1, r_i_data_rd_1,
      input  r_wr_en_2, r_i_addr_rd_2, r_i_data_rd_2,
      input  a_o_wr_cnt
   );

   // The arbiter itself
   modport slave (
      input  a_i_valid, a_i_addr, a_i_data, a_i_hold,
      output a_o_ready,
      output r_wr_en_1, r_i_addr_rd_1, r_i_data_rd_1,
      output r_wr_en_2, r_i_addr_rd_2, r_i_data_rd_2,
      output a_o_wr_cnt
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares two regfile write ports among four writeback requesters using a
// rotating round-robin scan. Writes to $0 are accepted and dropped, and a
// second write to the same rd in one cycle is pushed to a later cycle so the
// later requester wins the final register value.
module wb_port_arbiter #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREQ = 4
) (
   input logic             r_clk,
   input logic             r_rst,
   wb_port_arbiter_if.slave bus
);

   localparam int          PW      = $clog2(NREQ);
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [AW-1:0]   req_addr [NREQ];
   logic [DW-1:0]   req_data [NREQ];

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   scan_idx;
   logic [NREQ-1:0] ready;
   logic            slot1_vld;
   logic            slot2_vld;
   logic [PW-1:0]   slot1_idx;
   logic [PW-1:0]   slot2_idx;
   logic [PW-1:0]   last_idx;
   logic [1:0]      grant_cnt;
   logic [16:0]     cnt_sum;

   logic            wr_en_1;
   logic            wr_en_2;
   logic [AW-1:0]   addr_1;
   logic [AW-1:0]   addr_2;
   logic [DW-1:0]   data_1;
   logic [DW-1:0]   data_2;
   logic [15:0]     wr_cnt;

   genvar g;
   generate
      for (g = 0; g < NREQ; g++) begin : g_unpack
         assign req_addr[g] = bus.a_i_addr[g*AW +: AW];
         assign req_data[g] = bus.a_i_data[g*DW +: DW];
      end
   endgenerate

   // Scan requesters from rr_ptr: $0 writes are acked and dropped, the first
   // nonzero rd takes slot 1, the next one with a different rd takes slot 2.
   always_comb begin
      ready     = '0;
      slot1_vld = 1'b0;
      slot2_vld = 1'b0;
      slot1_idx = '0;
      slot2_idx = '0;
      scan_idx  = '0;
      if (r_rst && !bus.a_i_hold) begin
         for (int i = 0; i < NREQ; i++) begin
            scan_idx = rr_ptr + PW'(i);
            if (bus.a_i_valid[scan_idx]) begin
               if (req_addr[scan_idx] == '0) begin
                  ready[scan_idx] = 1'b1;
               end else if (!slot1_vld) begin
                  slot1_vld       = 1'b1;
                  slot1_idx       = scan_idx;
                  ready[scan_idx] = 1'b1;
               end else if (!slot2_vld && (req_addr[scan_idx] != req_addr[slot1_idx])) begin
                  slot2_vld       = 1'b1;
                  slot2_idx       = scan_idx;
                  ready[scan_idx] = 1'b1;
               end
            end
         end
      end
   end

   // Last nonzero winner in scan order and the saturating counter's next sum.
   always_comb begin
      last_idx  = slot2_vld ? slot2_idx : slot1_idx;
      grant_cnt = {1'b0, slot1_vld} + {1'b0, slot2_vld};
      cnt_sum   = {1'b0, wr_cnt} + {15'd0, grant_cnt};
   end

   // Rotate priority past the last nonzero winner; hold or $0-only cycles freeze it.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         rr_ptr <= '0;
      end else if (slot1_vld) begin
         rr_ptr <= last_idx + 1'b1;
      end
   end

   // Write port 1 register: enable pulses per grant, addr/data hold when idle.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         wr_en_1 <= 1'b0;
         addr_1  <= '0;
         data_1  <= '0;
      end else begin
         wr_en_1 <= slot1_vld;
         if (slot1_vld) begin
            addr_1 <= req_addr[slot1_idx];
            data_1 <= req_data[slot1_idx];
         end
      end
   end

   // Write port 2 register: same as port 1 but fed from slot 2.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         wr_en_2 <= 1'b0;
         addr_2  <= '0;
         data_2  <= '0;
      end else begin
         wr_en_2 <= slot2_vld;
         if (slot2_vld) begin
            addr_2 <= req_addr[slot2_idx];
            data_2 <= req_data[slot2_idx];
         end
      end
   end

   // Count issued regfile writes, sticking at all-ones instead of wrapping.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         wr_cnt <= '0;
      end else if (cnt_sum[16]) begin
         wr_cnt <= CNT_MAX;
      end else begin
         wr_cnt <= cnt_sum[15:0];
      end
   end

   assign bus.a_o_ready     = ready;
   assign bus.r_wr_en_1     = wr_en_1;
   assign bus.r_i_addr_rd_1 = addr_1;
   assign bus.r_i_data_rd_1 = data_1;
   assign bus.r_wr_en_2     = wr_en_2;
   assign bus.r_i_addr_rd_2 = addr_2;
   assign bus.r_i_data_rd_2 = data_2;
   assign bus.a_o_wr_cnt    = wr_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by a
// randomized phase, all compared against a list-based reference model and a
// regfile image built from the write-port pins.
module tb_wb_port_arbiter;

   localparam int AW          = 5;
   localparam int DW          = 32;
   localparam int NREQ        = 4;
   localparam int MODE_ONESHOT = 0;
   localparam int MODE_STREAM  = 1;
   localparam int MODE_RANDOM  = 2;

   logic r_clk = 1'b0;
   logic r_rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NREQ-1:0] req_valid;
   logic [AW-1:0]   req_addr [NREQ];
   logic [DW-1:0]   req_data [NREQ];
   logic            hold;
   logic [NREQ-1:0] obs_ready;

   int              m_ptr;
   int              m_cnt;
   int              m_s1;
   int              m_s2;
   logic [NREQ-1:0] m_ready;
   logic            m_en1;
   logic            m_en2;
   logic [AW-1:0]   m_a1;
   logic [AW-1:0]   m_a2;
   logic [DW-1:0]   m_d1;
   logic [DW-1:0]   m_d2;
   logic [DW-1:0]   m_rf   [32];
   logic [DW-1:0]   obs_rf [32];

   always #5 r_clk = ~r_clk;

   wb_port_arbiter_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();

   wb_port_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
      .r_clk (r_clk),
      .r_rst (r_rst),
      .bus   (bus)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus();
      bus.a_i_valid = req_valid;
      bus.a_i_hold  = hold;
      for (int k = 0; k < NREQ; k++) begin
         bus.a_i_addr[k*AW +: AW] = req_addr[k];
         bus.a_i_data[k*DW +: DW] = req_data[k];
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[k] = v;
      req_addr[k]  = a;
      req_data[k]  = d;
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_cnt   = 0;
      m_s1    = -1;
      m_s2    = -1;
      m_ready = '0;
      m_en1   = 1'b0;
      m_en2   = 1'b0;
      m_a1    = '0;
      m_a2    = '0;
      m_d1    = '0;
      m_d2    = '0;
   endtask

   // Expected grants: list the valid nonzero requesters in priority order,
   // the head wins port 1, the first later entry with another rd wins port 2.
   task automatic model_compute();
      int cand[$];
      int k;
      m_ready = '0;
      m_s1    = -1;
      m_s2    = -1;
      if (r_rst && !hold) begin
         for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (req_valid[k]) begin
               if (req_addr[k] == 0) m_ready[k] = 1'b1;
               else cand.push_back(k);
            end
         end
         if (cand.size() > 0) begin
            m_s1 = cand[0];
            for (int j = 1; j < cand.size(); j++) begin
               if (m_s2 < 0 && req_addr[cand[j]] != req_addr[m_s1]) m_s2 = cand[j];
            end
         end
         if (m_s1 >= 0) m_ready[m_s1] = 1'b1;
         if (m_s2 >= 0) m_ready[m_s2] = 1'b1;
      end
   endtask

   task automatic model_commit();
      int n;
      int last;
      n    = 0;
      last = -1;
      m_en1 = (m_s1 >= 0);
      m_en2 = (m_s2 >= 0);
      if (m_s1 >= 0) begin
         m_a1 = req_addr[m_s1];
         m_d1 = req_data[m_s1];
         n++;
         last = m_s1;
      end
      if (m_s2 >= 0) begin
         m_a2 = req_addr[m_s2];
         m_d2 = req_data[m_s2];
         n++;
         last = m_s2;
      end
      if (last >= 0) m_ptr = (last + 1) % NREQ;
      m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
   endtask

   // One clock: regfile writes land at the negedge, ready is checked there,
   // the registered ports and counter are checked just after the posedge.
   task automatic run_cycle(input string tag);
      apply_stimulus();
      @(negedge r_clk);
      #1;
      if (bus.r_wr_en_1) obs_rf[bus.r_i_addr_rd_1] = bus.r_i_data_rd_1;
      if (bus.r_wr_en_2) obs_rf[bus.r_i_addr_rd_2] = bus.r_i_data_rd_2;
      if (m_en1) m_rf[m_a1] = m_d1;
      if (m_en2) m_rf[m_a2] = m_d2;
      model_compute();
      obs_ready = bus.a_o_ready;
      check_output({tag, "_ready"}, obs_ready, m_ready);
      @(posedge r_clk);
      model_commit();
      #1;
      check_output({tag, "_en"}, {bus.r_wr_en_1, bus.r_wr_en_2}, {m_en1, m_en2});
      check_output({tag, "_port1"}, {bus.r_i_addr_rd_1, bus.r_i_data_rd_1}, {m_a1, m_d1});
      check_output({tag, "_port2"}, {bus.r_i_addr_rd_2, bus.r_i_data_rd_2}, {m_a2, m_d2});
      check_output({tag, "_cnt"}, bus.a_o_wr_cnt, 16'(m_cnt));
   endtask

   // After a handshake the requester moves on according to the scenario.
   task automatic refill_requests(input int mode);
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[k] && m_ready[k]) begin
            if (mode == MODE_ONESHOT) begin
               req_valid[k] = 1'b0;
            end else if (mode == MODE_STREAM) begin
               req_data[k] = $urandom;
            end else begin
               req_valid[k] = ($urandom_range(0, 3) != 0);
               req_addr[k]  = AW'($urandom_range(0, 7));
               req_data[k]  = $urandom;
            end
         end else if (!req_valid[k] && mode == MODE_RANDOM && $urandom_range(0, 1) == 1) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = AW'($urandom_range(0, 7));
            req_data[k]  = $urandom;
         end
      end
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < 32; r++) begin
         check_output($sformatf("%s_reg%0d", tag, r), obs_rf[r], m_rf[r]);
      end
   endtask

   initial begin
      int wait_cnt[NREQ];
      int max_wait;
      int cycles;

      hold = 1'b0;
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, AW'(k + 1), 32'hA1 + DW'(k));
      for (int r = 0; r < 32; r++) begin
         m_rf[r]   = '0;
         obs_rf[r] = '0;
      end
      model_reset();
      apply_stimulus();

      // Reset asserted with every requester valid
      #1 r_rst = 1'b0;
      #1;
      check_output("rst_ready", bus.a_o_ready, 4'b0000);
      check_output("rst_en", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);
      check_output("rst_port1", {bus.r_i_addr_rd_1, bus.r_i_data_rd_1}, 37'd0);
      check_output("rst_port2", {bus.r_i_addr_rd_2, bus.r_i_data_rd_2}, 37'd0);
      check_output("rst_cnt", bus.a_o_wr_cnt, 16'd0);
      repeat (2) @(posedge r_clk);
      #1;
      check_output("rst_held_en", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);
      #2 r_rst = 1'b1;
      #1;
      check_output("rel_en", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);

      // Full load: two pairs in two cycles, regs 1..4 get A1..A4
      run_cycle("full1");
      check_output("full1_ready_const", obs_ready, 4'b0011);
      refill_requests(MODE_ONESHOT);
      run_cycle("full2");
      check_output("full2_ready_const", obs_ready, 4'b1100);
      refill_requests(MODE_ONESHOT);
      run_cycle("full_idle");
      check_output("full_cnt", bus.a_o_wr_cnt, 16'd4);
      for (int r = 1; r <= 4; r++) check_output($sformatf("full_reg%0d", r), obs_rf[r], 32'hA0 + DW'(r));

      // Same-rd collision: later requester lands one cycle later and wins
      set_req(0, 1'b1, 5'd7, 32'h11);
      set_req(2, 1'b1, 5'd7, 32'h22);
      run_cycle("coll1");
      check_output("coll1_ready_const", obs_ready, 4'b0001);
      check_output("coll1_en_const", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b10);
      refill_requests(MODE_ONESHOT);
      run_cycle("coll2");
      check_output("coll2_ready_const", obs_ready, 4'b0100);
      check_output("coll2_port1_const", {bus.r_i_addr_rd_1, bus.r_i_data_rd_1}, {5'd7, 32'h22});
      refill_requests(MODE_ONESHOT);
      run_cycle("coll_idle");
      check_output("coll_reg7", obs_rf[7], 32'h22);

      // $0 write accepted alongside a real write, only the real one issues
      set_req(1, 1'b1, 5'd0, 32'hEE);
      set_req(3, 1'b1, 5'd9, 32'h55);
      run_cycle("zero1");
      check_output("zero1_ready_const", obs_ready, 4'b1010);
      check_output("zero1_port1_const", {bus.r_wr_en_1, bus.r_wr_en_2, bus.r_i_addr_rd_1, bus.r_i_data_rd_1},
                   {2'b10, 5'd9, 32'h55});
      refill_requests(MODE_ONESHOT);
      run_cycle("zero_idle");
      check_output("zero_cnt", bus.a_o_wr_cnt, 16'd7);
      check_output("zero_reg0", obs_rf[0], 32'h0);
      check_output("zero_reg9", obs_rf[9], 32'h55);

      // Hold blocks grants, release grants on the next edge for one cycle
      hold = 1'b1;
      set_req(2, 1'b1, 5'd12, 32'h77);
      run_cycle("hold1");
      check_output("hold1_ready_const", obs_ready, 4'b0000);
      run_cycle("hold2");
      check_output("hold2_en_const", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);
      hold = 1'b0;
      run_cycle("hold_rel");
      check_output("hold_rel_ready_const", obs_ready, 4'b0100);
      check_output("hold_rel_en_const", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b10);
      refill_requests(MODE_ONESHOT);
      run_cycle("hold_after");
      check_output("hold_after_en_const", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);

      // Fairness: two streams both served every cycle, then three rotate
      set_req(0, 1'b1, 5'd3, $urandom);
      set_req(3, 1'b1, 5'd5, $urandom);
      for (int c = 0; c < 4; c++) begin
         run_cycle("fair2");
         check_output("fair2_ready_const", obs_ready, 4'b1001);
         refill_requests(MODE_STREAM);
      end
      req_valid[0] = 1'b0;
      set_req(1, 1'b1, 5'd10, $urandom);
      set_req(2, 1'b1, 5'd11, $urandom);
      set_req(3, 1'b1, 5'd12, $urandom);
      max_wait = 0;
      for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
      for (int c = 0; c < 9; c++) begin
         run_cycle("fair3");
         for (int k = 1; k < NREQ; k++) begin
            if (req_valid[k] && !obs_ready[k]) wait_cnt[k]++;
            else wait_cnt[k] = 0;
            if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
         end
         refill_requests(MODE_STREAM);
      end
      check_output("fair3_max_wait_le2", 64'(max_wait <= 2), 64'd1);
      req_valid = '0;
      run_cycle("fair_idle");
      check_regs("fair");

      // Reset in the middle of traffic: launched writes are lost
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, AW'(k + 1), 32'hB1 + DW'(k));
      run_cycle("rm1");
      refill_requests(MODE_STREAM);
      #2 r_rst = 1'b0;
      model_reset();
      #1;
      check_output("rm_ready", bus.a_o_ready, 4'b0000);
      check_output("rm_en", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);
      check_output("rm_port1", {bus.r_i_addr_rd_1, bus.r_i_data_rd_1}, 37'd0);
      check_output("rm_cnt", bus.a_o_wr_cnt, 16'd0);
      @(posedge r_clk);
      #3 r_rst = 1'b1;
      #1;
      check_output("rm_rel_en", {bus.r_wr_en_1, bus.r_wr_en_2}, 2'b00);
      run_cycle("rm2");
      check_output("rm2_ready_const", obs_ready, 4'b0011);
      refill_requests(MODE_STREAM);
      run_cycle("rm3");
      check_output("rm3_ready_const", obs_ready, 4'b1100);
      req_valid = '0;
      run_cycle("rm_idle");
      check_regs("rm");

      // Randomized traffic with small rd range for zeros and collisions
      for (int c = 0; c < 400; c++) begin
         hold = ($urandom_range(0, 7) == 0);
         run_cycle("rnd");
         refill_requests(MODE_RANDOM);
      end
      hold      = 1'b0;
      req_valid = '0;
      run_cycle("rnd_idle");
      check_regs("rnd");

      // Counter saturation under continuous full load
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, AW'(k + 1), 32'hC1 + DW'(k));
      apply_stimulus();
      cycles = 0;
      while (bus.a_o_wr_cnt !== 16'hFFFF && cycles < 40000) begin
         @(posedge r_clk);
         #1;
         cycles++;
      end
      check_output("sat_reached", 64'(cycles < 40000), 64'd1);
      repeat (3) @(posedge r_clk);
      #1;
      check_output("sat_hold", bus.a_o_wr_cnt, 16'hFFFF);
      req_valid = '0;
      apply_stimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
